// File: rtl/h264_quant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : h264_quant_pkg
// Purpose  : Shared H.264 quantiser constants and types: block modes,
//            multiplication-factor table, zigzag-to-class map, QP split helper.
// Revision : 1.0 - initial release
// ============================================================================
package h264_quant_pkg;

  typedef enum logic [1:0] {
    BLK_4X4       = 2'd0,
    BLK_LUMA_DC   = 2'd1,
    BLK_CHROMA_DC = 2'd2,
    BLK_RSVD      = 2'd3
  } blk_mode_t;

  localparam int c_mf_w = 14;

  // Coefficient class indices into the MF table columns
  localparam logic [1:0] c_cls_a = 2'd0;
  localparam logic [1:0] c_cls_b = 2'd1;
  localparam logic [1:0] c_cls_c = 2'd2;

  // MF[qp % 6][class], class order A, B, C
  localparam logic [c_mf_w-1:0] c_mf_tab [6][3] = '{
    '{14'd13107, 14'd5243, 14'd8066},
    '{14'd11916, 14'd4660, 14'd7490},
    '{14'd10082, 14'd4194, 14'd6554},
    '{14'd9362,  14'd3647, 14'd5825},
    '{14'd8192,  14'd3355, 14'd5243},
    '{14'd7282,  14'd2893, 14'd4559}
  };

  // Class of each zigzag scan position in a 4x4 residual block
  localparam logic [1:0] c_zz_class [16] = '{
    c_cls_a, c_cls_c, c_cls_c, c_cls_a, c_cls_b, c_cls_a, c_cls_c, c_cls_c,
    c_cls_c, c_cls_c, c_cls_b, c_cls_a, c_cls_b, c_cls_c, c_cls_c, c_cls_b
  };

  typedef struct packed {
    logic [3:0] qdiv;
    logic [2:0] qmod;
  } qp_split_t;

  // Clamp QP to 51 and split it into QP/6 and QP%6 without a divider
  function automatic qp_split_t qp_split(input logic [5:0] qp);
    qp_split_t  r;
    logic [5:0] q;
    q      = (qp > 6'd51) ? 6'd51 : qp;
    r.qdiv = 4'd0;
    r.qmod = q[2:0];
    for (int i = 1; i <= 8; i++) begin
      if (q >= 6'(6 * i)) begin
        r.qdiv = 4'(i);
        r.qmod = 3'(q - 6'(6 * i));
      end
    end
    return r;
  endfunction

endpackage : h264_quant_pkg
`default_nettype wire

// File: rtl/h264_quant_mf_sel.sv
`default_nettype none
// ============================================================================
// Module   : h264_quant_mf_sel
// Purpose  : Stage-1 multiplication-factor lookup, registered. Picks the
//            coefficient class from the zigzag position (4x4 residual) or
//            class A (DC blocks), then reads MF for the current qp % 6.
// Revision : 1.0 - initial release
// ============================================================================
module h264_quant_mf_sel
  import h264_quant_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [3:0]        i_pos,
  input  blk_mode_t         i_mode,
  input  logic [2:0]        i_qmod,
  output logic [c_mf_w-1:0] o_mf
);

  logic [1:0] w_cls;

  // DC blocks always use class A; residual blocks use the position map
  always_comb begin
    w_cls = c_cls_a;
    if (i_mode == BLK_4X4 || i_mode == BLK_RSVD) begin
      w_cls = c_zz_class[i_pos];
    end
  end

  // Register the looked-up factor alongside the other stage-1 fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mf <= '0;
    end else if (i_en) begin
      o_mf <= c_mf_tab[i_qmod][w_cls];
    end
  end

endmodule : h264_quant_mf_sel
`default_nettype wire

// File: rtl/h264_quant_pipe.sv
`default_nettype none
// ============================================================================
// Module   : h264_quant_pipe
// Purpose  : Four-stage H.264 forward quantiser with valid/ready handshake.
//            S1 capture + MF, S2 multiply, S3 round + shift, S4 sign,
//            saturate and nonzero count. Whole pipe stalls on backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module h264_quant_pipe
  import h264_quant_pkg::*;
#(
  parameter int IW = 16,
  parameter int OW = 12
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic signed [IW-1:0] YNIN,
  input  logic [5:0]           QP,
  input  logic                 INTRA,
  input  logic [1:0]           BLK_MODE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic signed [OW-1:0] ZOUT,
  output logic                 ZLAST,
  output logic [4:0]           NZCOUNT
);

  localparam int LAT = 4;
  localparam int PW  = IW + c_mf_w;
  localparam int SW  = PW + 1;
  // floor(2^26 / 3); shifting right gives floor(2^q / 3) for any q <= 26
  localparam logic [25:0]   c_third = 26'h1555555;
  localparam logic [SW-1:0] c_sat   = SW'((1 << (OW - 1)) - 1);

  logic            w_adv, w_fire, w_first, w_last, w_intra;
  blk_mode_t       w_in_mode, w_mode;
  qp_split_t       w_qps;
  logic [3:0]      w_qdiv;
  logic [2:0]      w_qmod;
  logic [IW-1:0]   w_ymag;

  logic [3:0]      r_pos;
  blk_mode_t       r_mode;
  logic            r_intra;
  logic [3:0]      r_qdiv;
  logic [2:0]      r_qmod;
  logic [LAT-1:0]  r_vld;

  logic            r1_sign, r1_intra, r1_last;
  logic [IW-1:0]   r1_mag;
  logic [4:0]      r1_qbits;
  logic [c_mf_w-1:0] w1_mf;

  logic            r2_sign, r2_intra, r2_last;
  logic [PW-1:0]   r2_prod;
  logic [4:0]      r2_qbits;

  logic [25:0]     w_f3;
  logic [SW-1:0]   w_f, w_sum;
  logic            r3_sign, r3_last;
  logic [SW-1:0]   r3_mag;

  logic [OW-1:0]   w_sat;
  logic            w_nz;
  logic [4:0]      w_nzsum, r_nzacc;
  logic signed [OW-1:0] r_zout;
  logic            r_zlast;
  logic [4:0]      r_nzcnt;

  // Every stage moves together whenever the output slot can be vacated
  assign OUT_VALID = r_vld[LAT-1];
  assign w_adv     = !OUT_VALID || OUT_READY;
  assign IN_READY  = w_adv;
  assign w_fire    = IN_VALID && w_adv;
  assign ZOUT      = r_zout;
  assign ZLAST     = r_zlast;
  assign NZCOUNT   = r_nzcnt;

  // Block parameters come straight from the ports on position 0, else latched
  always_comb begin
    w_in_mode = (BLK_MODE == 2'd3) ? BLK_4X4 : blk_mode_t'(BLK_MODE);
    w_first   = (r_pos == 4'd0);
    w_qps     = qp_split(QP);
    w_mode    = w_first ? w_in_mode : r_mode;
    w_intra   = w_first ? INTRA : r_intra;
    w_qdiv    = w_first ? w_qps.qdiv : r_qdiv;
    w_qmod    = w_first ? w_qps.qmod : r_qmod;
    w_last    = (r_pos == ((w_mode == BLK_CHROMA_DC) ? 4'd3 : 4'd15));
    w_ymag    = YNIN[IW-1] ? (~YNIN + 1'b1) : YNIN;
  end

  // Position counter and per-block parameter latch
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pos   <= 4'd0;
      r_mode  <= BLK_4X4;
      r_intra <= 1'b0;
      r_qdiv  <= 4'd0;
      r_qmod  <= 3'd0;
    end else if (w_fire) begin
      r_pos <= w_last ? 4'd0 : r_pos + 4'd1;
      if (w_first) begin
        r_mode  <= w_in_mode;
        r_intra <= INTRA;
        r_qdiv  <= w_qps.qdiv;
        r_qmod  <= w_qps.qmod;
      end
    end
  end

  h264_quant_mf_sel u_mf_sel (
    .clk    (CLK),
    .rst    (RESET),
    .i_en   (w_adv),
    .i_pos  (r_pos),
    .i_mode (w_mode),
    .i_qmod (w_qmod),
    .o_mf   (w1_mf)
  );

  // Stage valid flags shift with the pipeline
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[LAT-2:0], w_fire};
    end
  end

  // S1: sign-magnitude capture and per-coefficient shift amount
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r1_sign  <= 1'b0;
      r1_mag   <= '0;
      r1_qbits <= 5'd0;
      r1_intra <= 1'b0;
      r1_last  <= 1'b0;
    end else if (w_adv) begin
      r1_sign  <= YNIN[IW-1];
      r1_mag   <= w_ymag;
      r1_qbits <= ((w_mode == BLK_4X4) ? 5'd15 : 5'd16) + {1'b0, w_qdiv};
      r1_intra <= w_intra;
      r1_last  <= w_last;
    end
  end

  // S2: magnitude times multiplication factor
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r2_sign  <= 1'b0;
      r2_prod  <= '0;
      r2_qbits <= 5'd0;
      r2_intra <= 1'b0;
      r2_last  <= 1'b0;
    end else if (w_adv) begin
      r2_sign  <= r1_sign;
      r2_prod  <= PW'(r1_mag) * PW'(w1_mf);
      r2_qbits <= r1_qbits;
      r2_intra <= r1_intra;
      r2_last  <= r1_last;
    end
  end

  // Rounding offset: 2^qbits/3 for intra, 2^qbits/6 for inter
  always_comb begin
    w_f3  = c_third >> (5'd26 - r2_qbits);
    w_f   = r2_intra ? SW'(w_f3) : SW'(w_f3 >> 1);
    w_sum = SW'(r2_prod) + w_f;
  end

  // S3: round and shift the unsigned magnitude
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r3_sign <= 1'b0;
      r3_mag  <= '0;
      r3_last <= 1'b0;
    end else if (w_adv) begin
      r3_sign <= r2_sign;
      r3_mag  <= w_sum >> r2_qbits;
      r3_last <= r2_last;
    end
  end

  // Symmetric saturation keeps the most negative code unreachable
  always_comb begin
    w_sat   = (r3_mag > c_sat) ? c_sat[OW-1:0] : r3_mag[OW-1:0];
    w_nz    = |r3_mag;
    w_nzsum = r_nzacc + {4'd0, w_nz};
  end

  // S4: output register, sign restore and per-block nonzero count
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_zout  <= '0;
      r_zlast <= 1'b0;
      r_nzcnt <= 5'd0;
      r_nzacc <= 5'd0;
    end else if (w_adv) begin
      if (r_vld[LAT-2]) begin
        r_zout  <= r3_sign ? -w_sat : w_sat;
        r_zlast <= r3_last;
        r_nzcnt <= w_nzsum;
        r_nzacc <= r3_last ? 5'd0 : w_nzsum;
      end else begin
        r_zlast <= 1'b0;
      end
    end
  end

endmodule : h264_quant_pipe
`default_nettype wire

// File: tb/tb_h264_quant_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_h264_quant_pipe
// Purpose  : Self-checking bench for h264_quant_pipe: directed vectors plus
//            randomized blocks against a behavioural quantiser model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_h264_quant_pipe;

  localparam int IW = 16;
  localparam int OW = 12;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 IN_VALID, IN_READY, INTRA, OUT_VALID, OUT_READY, ZLAST;
  logic signed [IW-1:0] YNIN;
  logic [5:0]           QP;
  logic [1:0]           BLK_MODE;
  logic signed [OW-1:0] ZOUT;
  logic [4:0]           NZCOUNT;

  h264_quant_pipe #(.IW(IW), .OW(OW)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .YNIN(YNIN), .QP(QP), .INTRA(INTRA), .BLK_MODE(BLK_MODE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ZOUT(ZOUT),
    .ZLAST(ZLAST), .NZCOUNT(NZCOUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int y; int qp; bit intra; int mode;
    bit spot; int spot_lvl; bit spot_nz; int nz_exp;
  } item_t;

  typedef struct {
    int lvl; bit last; int nz; int adv_at;
    bit spot; int spot_lvl; bit spot_nz; int nz_exp;
  } exp_t;

  item_t src[$];
  exp_t  sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int stall_pct = 0, gap_pct = 0, stall_left = 0, adv_cnt = 0;
  bit held_v = 0;
  int h_z, h_l, h_n;

  int m_pos = 0, m_qp = 0, m_mode = 0, m_nz = 0;
  bit m_intra = 0;

  // Count one comparison and report it when it does not match
  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference quantiser straight from the arithmetic definition
  function automatic int quant(int y, int qp, bit intra, int mode, int pos);
    int tab [6][3];
    int cls, qbits;
    longint mag, f, lvl, maxv;
    tab = '{'{13107, 5243, 8066}, '{11916, 4660, 7490}, '{10082, 4194, 6554},
            '{9362, 3647, 5825},  '{8192, 3355, 5243},  '{7282, 2893, 4559}};
    if (mode == 0)
      cls = (pos inside {0, 3, 5, 11}) ? 0 : (pos inside {4, 10, 12, 15}) ? 1 : 2;
    else
      cls = 0;
    qbits = ((mode == 0) ? 15 : 16) + qp / 6;
    f     = (longint'(1) << qbits) / (intra ? 3 : 6);
    mag   = (y < 0) ? -longint'(y) : longint'(y);
    lvl   = (mag * tab[qp % 6][cls] + f) >> qbits;
    maxv  = (longint'(1) << (OW - 1)) - 1;
    if (lvl > maxv) lvl = maxv;
    return (y < 0) ? -int'(lvl) : int'(lvl);
  endfunction

  // Block bookkeeping: params on first coefficient, count nonzeros, mark last
  function automatic void model_accept(item_t it, int adv_now);
    exp_t e;
    int   n;
    if (m_pos == 0) begin
      m_qp    = (it.qp > 51) ? 51 : it.qp;
      m_intra = it.intra;
      m_mode  = (it.mode == 3) ? 0 : it.mode;
    end
    n        = (m_mode == 2) ? 4 : 16;
    e.lvl    = quant(it.y, m_qp, m_intra, m_mode, m_pos);
    if (e.lvl != 0) m_nz++;
    e.last   = (m_pos == n - 1);
    e.nz     = m_nz;
    e.adv_at = adv_now;
    e.spot   = it.spot;  e.spot_lvl = it.spot_lvl;
    e.spot_nz = it.spot_nz; e.nz_exp = it.nz_exp;
    if (e.last) begin m_nz = 0; m_pos = 0; end
    else m_pos++;
    sb.push_back(e);
  endfunction

  function automatic item_t mk(int y, int qp, bit intra, int mode);
    item_t it;
    it.y = y; it.qp = qp; it.intra = intra; it.mode = mode;
    it.spot = 0; it.spot_lvl = 0; it.spot_nz = 0; it.nz_exp = 0;
    return it;
  endfunction

  function automatic int rnd_y(int kind);
    case (kind)
      0:       return int'($urandom_range(600)) - 300;
      1:       return int'($signed(16'($urandom)));
      default: return ($urandom_range(3) == 0) ? int'($urandom_range(200)) - 100 : 0;
    endcase
  endfunction

  task automatic push_block(int mode, int qp, bit intra, int kind);
    int n = (mode == 2) ? 4 : 16;
    for (int i = 0; i < n; i++) src.push_back(mk(rnd_y(kind), qp, intra, mode));
  endtask

  // Mode-0 block whose first coefficient carries a literal expected level
  task automatic push_spot_block(int qp, bit intra, int y0, int lvl0);
    item_t it;
    it = mk(y0, qp, intra, 0);
    it.spot = 1; it.spot_lvl = lvl0;
    src.push_back(it);
    for (int i = 1; i < 16; i++) src.push_back(mk(rnd_y(0), qp, intra, 0));
  endtask

  // One clock cycle: drive at negedge, check and score 1 time unit later
  task automatic step();
    bit    adv;
    item_t it;
    exp_t  e;
    @(negedge CLK);
    if (stall_left > 0) begin OUT_READY = 1'b0; stall_left--; end
    else OUT_READY = ($urandom_range(99) >= stall_pct);
    if (src.size() > 0 && $urandom_range(99) >= gap_pct) begin
      it = src[0];
      IN_VALID = 1'b1; YNIN = IW'(it.y); QP = 6'(it.qp);
      INTRA = it.intra; BLK_MODE = 2'(it.mode);
    end else begin
      IN_VALID = 1'b0; YNIN = IW'($urandom); QP = 6'($urandom);
      INTRA = 1'($urandom); BLK_MODE = 2'($urandom);
    end
    #1;
    adv = !OUT_VALID || OUT_READY;
    chk("in_ready", IN_READY, adv);
    if (held_v) begin
      chk("hold_valid", OUT_VALID, 1);
      chk("hold_zout", ZOUT, h_z);
      chk("hold_zlast", ZLAST, h_l);
      chk("hold_nzcount", NZCOUNT, h_n);
    end
    if (OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) chk("spurious_out", OUT_VALID, 0);
      else begin
        e = sb.pop_front();
        chk("zout", ZOUT, e.lvl);
        chk("zlast", ZLAST, e.last);
        chk("latency", adv_cnt - e.adv_at, 4);
        if (e.last) chk("nzcount", NZCOUNT, e.nz);
        if (e.spot) chk("spot_zout", ZOUT, e.spot_lvl);
        if (e.spot_nz) begin
          chk("spot_zlast", ZLAST, 1);
          chk("spot_nzcount", NZCOUNT, e.nz_exp);
        end
      end
    end
    if (IN_VALID && IN_READY) begin
      it = src.pop_front();
      model_accept(it, adv_cnt);
    end
    held_v = OUT_VALID && !OUT_READY;
    h_z = ZOUT; h_l = ZLAST; h_n = NZCOUNT;
    if (adv) adv_cnt++;
  endtask

  task automatic drain(input int budget, output int used);
    int k = 0;
    while ((src.size() > 0 || sb.size() > 0) && k < budget) begin step(); k++; end
    if (k >= budget) chk("drain_timeout", src.size() + sb.size(), 0);
    used = k;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_out_valid"}, OUT_VALID, 0);
    chk({tag, "_zout"}, ZOUT, 0);
    chk({tag, "_zlast"}, ZLAST, 0);
    chk({tag, "_nzcount"}, NZCOUNT, 0);
  endtask

  initial begin
    int    used;
    item_t it;
    RESET = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    YNIN = '0; QP = '0; INTRA = 1'b0; BLK_MODE = 2'd0;
    #2 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    #1 chk_reset_outputs("reset");
    chk("reset_in_ready", IN_READY, 1);
    @(negedge CLK) RESET = 1'b0;

    // Literal vectors: rounding, sign symmetry and saturation
    push_spot_block(0, 1, 100, 40);
    push_spot_block(0, 1, -100, -40);
    push_spot_block(0, 1, 32767, 2047);
    push_spot_block(0, 1, -32767, -2047);
    drain(500, used);

    // Chroma DC zero block then a residual block, streamed without a bubble
    for (int i = 0; i < 4; i++) begin
      it = mk(0, 28, 1, 2);
      it.spot = 1; it.spot_lvl = 0;
      if (i == 3) begin it.spot_nz = 1; it.nz_exp = 0; end
      src.push_back(it);
    end
    push_block(0, 20, 0, 0);
    drain(200, used);
    chk("no_bubble_cycles", used, 24);

    // Backpressure for 3 cycles in the middle of a block
    push_block(0, 15, 1, 1);
    for (int i = 0; i < 8; i++) step();
    stall_left = 3;
    drain(200, used);

    // Exactly three nonzero inputs in an inter block at QP 10
    for (int i = 0; i < 16; i++) begin
      it = mk((i == 0 || i == 7) ? 1000 : (i == 4) ? -1000 : 0, 10, 0, 0);
      if (i == 0) begin it.spot = 1; it.spot_lvl = 125; end
      if (i == 4) begin it.spot = 1; it.spot_lvl = -51; end
      if (i == 15) begin it.spot_nz = 1; it.nz_exp = 3; end
      src.push_back(it);
    end
    drain(200, used);

    // Reset after the 7th coefficient of a block
    for (int i = 0; i < 7; i++) src.push_back(mk(rnd_y(0), 5, 1, 0));
    while (src.size() > 0) step();
    @(negedge CLK);
    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    #1 chk_reset_outputs("midblk_rst");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    sb.delete(); m_pos = 0; m_nz = 0; held_v = 0;
    for (int i = 0; i < 16; i++) begin
      it = mk(rnd_y(0), 12, 1, 0);
      if (i == 15) begin it.spot_nz = 0; end
      src.push_back(it);
    end
    drain(200, used);

    // Randomized blocks with stalls and input gaps
    stall_pct = 25; gap_pct = 20;
    for (int b = 0; b < 40; b++)
      push_block(int'($urandom_range(3)), int'($urandom_range(63)), 1'($urandom),
                 int'($urandom_range(2)));
    drain(20000, used);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule : tb_h264_quant_pipe
`default_nettype wire
